seg_scan_disp: RTL and testbench

- Downstream display stage for the traffic-light controller.
- Consumes the 8-bit remaining-seconds value (0..255) that the controller produces.
- Converts the value to 3 BCD digits with an iterative double-dabble engine.
- Time-multiplexes the digits onto one common 7-segment bus (active-low segments and digit enables) using the system clock.

---
 rtl/seg_scan_disp_if.sv | 10 +
 rtl/seg_scan_disp.sv | 153 +++++++++++++++
 tb/tb_seg_scan_disp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_disp_if.sv
// Display-side bundle for seg_scan_disp: seconds value in, multiplexed 7-segment drive out.
interface seg_scan_disp_if;
  logic [7:0] bits;
  logic [6:0] seg;
  logic [2:0] dig;
  logic       bcd_valid;

  modport master (output bits, input seg, input dig, input bcd_valid);
  modport slave  (input bits, output seg, output dig, output bcd_valid);
endinterface

// File: rtl/seg_scan_disp.sv
// 8-bit seconds -> 3-digit BCD (iterative double-dabble) -> scanned common 7-segment bus.
// Optional macro SEG_BLANK_EN: blank leading-zero hundreds/tens digits.
module seg_scan_disp #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  seg_scan_disp_if.slave bus
);

  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [19:0] CNT_LAST = 20'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  bits_q, bits_d;
  logic [7:0]  last_conv_q, last_conv_d;
  logic [19:0] shreg_q, shreg_d;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [19:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  dig_q, dig_d;
  logic [6:0]  seg_q, seg_d;

  logic [19:0] adj;
  logic        wrap;
  logic [1:0]  idx_next;
  logic [3:0]  nib_sel;
  logic        blank;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  assign adj[7:0] = shreg_q[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    logic [3:0] nib;
    assign nib                  = shreg_q[8 + 4*gi +: 4];
    assign adj[8 + 4*gi +: 4]   = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign bits_d = bus.bits;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    iter_d      = iter_q;
    last_conv_d = last_conv_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    unique case (state_q)
      S_IDLE: begin
        if (bits_q != last_conv_q) begin
          shreg_d     = {12'h000, bits_q};
          last_conv_d = bits_q;
          iter_d      = 3'd0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = {adj[18:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = S_DONE;
      end
      S_DONE: begin
        hund_d  = shreg_q[19:16];
        tens_d  = shreg_q[15:12];
        ones_d  = shreg_q[11:8];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs only move on a wrap, and dig/seg both follow the new index.
  always_comb begin
    wrap       = (scan_cnt_q == CNT_LAST);
    scan_cnt_d = wrap ? 20'd0 : scan_cnt_q + 20'd1;
    idx_next   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    idx_d      = wrap ? idx_next : idx_q;
    case (idx_next)
      2'd0:    nib_sel = ones_q;
      2'd1:    nib_sel = tens_q;
      default: nib_sel = hund_q;
    endcase
`ifdef SEG_BLANK_EN
    blank = ((idx_next == 2'd2) && (hund_q == 4'd0)) ||
            ((idx_next == 2'd1) && (hund_q == 4'd0) && (tens_q == 4'd0));
`else
    blank = 1'b0;
`endif
    dig_d = dig_q;
    seg_d = seg_q;
    if (wrap) begin
      dig_d = ~(3'b001 << idx_next);
      if (blank)               seg_d = SEG_OFF;
      else if (SEG_ACTIVE_LOW) seg_d = ~decode(nib_sel);
      else                     seg_d = decode(nib_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bits_q      <= 8'd0;
      last_conv_q <= 8'd0;
      shreg_q     <= 20'd0;
      iter_q      <= 3'd0;
      hund_q      <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      scan_cnt_q  <= 20'd0;
      idx_q       <= 2'd0;
      dig_q       <= 3'b111;
      seg_q       <= SEG_OFF;
    end else begin
      state_q     <= state_d;
      bits_q      <= bits_d;
      last_conv_q <= last_conv_d;
      shreg_q     <= shreg_d;
      iter_q      <= iter_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dig       = dig_q;
  assign bus.bcd_valid = (state_q == S_IDLE) && (bits_q == last_conv_q);

endmodule

// File: tb/tb_seg_scan_disp.sv
// Randomized scoreboard bench for seg_scan_disp: expected values queued at stimulus, checked per scan round.
module tb_seg_scan_disp;
  localparam int SCAN_DIV = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  seg_scan_disp_if bus ();

  seg_scan_disp #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit mon_busy  = 1'b0;
  bit check_now = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digit at a position, then table lookup, blanking, active-low.
  function automatic logic [6:0] exp_seg(input int v, input int pos);
    int d;
    bit blank;
    d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
    blank = 1'b0;
`ifdef SEG_BLANK_EN
    blank = (pos == 2 && v < 100) || (pos == 1 && v < 10);
`endif
    return blank ? 7'h7F : ~SEG_TAB[d];
  endfunction

  function automatic int dig_pos(input logic [2:0] d);
    case (d)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [2:0] dig_rot(input logic [2:0] d);
    case (d)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // Watch one full scan round and compare every digit position.
  task automatic check_display(input int v);
    logic [2:0] dprev;
    int cnt, pos;
    dprev = bus.dig;
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (bus.dig == dprev && cnt < 3 * SCAN_DIV + 5);
      if (bus.dig == dprev) begin
        chk("scan_timeout", 1, 0);
        return;
      end
      pos = dig_pos(bus.dig);
      chk("dig_onehot", int'(pos >= 0), 1);
      if (k > 0 && dprev != 3'b111) begin
        chk("dig_order", bus.dig, dig_rot(dprev));
        chk("scan_period", cnt, SCAN_DIV);
      end
      if (pos >= 0) chk($sformatf("seg_v%0d_p%0d", v, pos), bus.seg, exp_seg(v, pos));
      dprev = bus.dig;
    end
    $display("txn value=%0d digits=%0d/%0d/%0d checked", v, v / 100, (v / 10) % 10, v % 10);
  endtask

  // Monitor: a rising bcd_valid means a new value reached the display regs.
  initial begin
    bit prev_valid = 1'b0;
    int v;
    forever begin
      @(negedge clk);
      if (rst_n && ((bus.bcd_valid && !prev_valid) || check_now)) begin
        check_now = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          mon_busy = 1'b1;
          v = exp_q.pop_front();
          check_display(v);
          mon_busy = 1'b0;
        end
      end
      prev_valid = bus.bcd_valid;
    end
  end

  task automatic measure_low(input int start, input int exp_low, input string name);
    int n = start;
    int guard = 0;
    while (guard < 80) begin
      @(posedge clk);
      #1;
      guard++;
      if (bus.bcd_valid) break;
      n++;
    end
    chk(name, n, exp_low);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || mon_busy) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    chk("scoreboard_drain", exp_q.size() + int'(mon_busy), 0);
  endtask

  task automatic convert(input logic [7:0] v, input string name);
    @(negedge clk);
    bus.bits = v;
    exp_q.push_back(int'(v));
    measure_low(0, 10, name);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur, v;
    int n;
    bus.bits = 8'd0;
    #23;
    chk("rst_dig", bus.dig, 3'b111);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_valid", bus.bcd_valid, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", bus.bcd_valid, 1);
    chk("post_rst_dig", bus.dig, 3'b111);
    chk("post_rst_seg", bus.seg, 7'h7F);
    exp_q.push_back(0);
    check_now = 1'b1;
    wait_idle();

    convert(8'd57, "lat_57");
    convert(8'd255, "lat_255");
    convert(8'd100, "lat_100");
    convert(8'd9, "lat_9");
    convert(8'd10, "lat_10");
    convert(8'd7, "lat_7");

    // Change during conversion: only the latest value should settle.
    @(negedge clk);
    bus.bits = 8'd45;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      if (!bus.bcd_valid) n++;
    end
    bus.bits = 8'd3;
    exp_q.push_back(3);
    measure_low(n, 20, "lat_45_then_3");
    wait_idle();
    cur = 8'd3;

    for (int i = 0; i < 20; i++) begin
      v = 8'($urandom_range(0, 255));
      if (v == cur) v = v ^ 8'h01;
      convert(v, "lat_rand");
      cur = v;
    end

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bus.bits = 8'd200;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_dig", bus.dig, 3'b111);
    chk("async_rst_seg", bus.seg, 7'h7F);
    chk("async_rst_valid", bus.bcd_valid, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(200);
    measure_low(0, 10, "lat_after_rst");
    wait_idle();

    convert(8'd0, "lat_0");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
